// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between two writeback requesters, each
// buffered by a small FIFO, with round-robin grant and a pending-write scoreboard.
module regfile_write_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              reserve_valid,
    input  logic [ADDR_W-1:0] reserve_addr,
    output logic              reserve_conflict,
    output logic [31:0]       busy,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] rc,
    output logic [DATA_W-1:0] dc,
    output logic              idle
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [1:0]        in_valid;
    logic [1:0]        in_ready;
    logic [1:0]        push;
    logic [1:0]        pop;
    logic [1:0]        not_empty;
    logic [ADDR_W-1:0] in_addr   [2];
    logic [DATA_W-1:0] in_data   [2];
    logic [ADDR_W-1:0] head_addr [2];
    logic [DATA_W-1:0] head_data [2];

    assign in_valid   = {req1_valid, req0_valid};
    assign in_addr[0] = req0_addr;
    assign in_addr[1] = req1_addr;
    assign in_data[0] = req0_data;
    assign in_data[1] = req1_data;
    assign req0_ready = in_ready[0];
    assign req1_ready = in_ready[1];

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
        logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
        logic [PTR_W-1:0]  wr_ptr;
        logic [PTR_W-1:0]  rd_ptr;
        logic [CNT_W-1:0]  count;

        // Ready is a pure function of occupancy so a full FIFO never takes a push.
        assign in_ready[g]  = (count != CNT_W'(FIFO_DEPTH));
        assign not_empty[g] = (count != '0);
        assign push[g]      = in_valid[g] && in_ready[g];
        assign head_addr[g] = addr_mem[rd_ptr];
        assign head_data[g] = data_mem[rd_ptr];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                // NOTE: non-blocking assignments so every register samples pre-edge values.
                if (push[g]) wr_ptr <= wr_ptr + 1'b1;
                if (pop[g])  rd_ptr <= rd_ptr + 1'b1;
                count <= count + CNT_W'(push[g]) - CNT_W'(pop[g]);
            end
        end

        // NOTE: storage has no reset; pointers and count alone define which entries are live.
        always_ff @(posedge clk) begin
            if (push[g]) begin
                addr_mem[wr_ptr] <= in_addr[g];
                data_mem[wr_ptr] <= in_data[g];
            end
        end
    end

    logic              last_gnt;   // 1 = requester 1 was granted last
    logic              gnt_valid;
    logic              gnt_sel;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_data;
    logic [31:0]       clr_mask;
    logic [31:0]       set_mask;
    logic [31:0]       busy_next;
    logic              conflict_next;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        gnt_valid = |not_empty;
        gnt_sel   = not_empty[1];
        if (not_empty == 2'b11) gnt_sel = ~last_gnt;
    end

    assign pop      = gnt_valid ? (gnt_sel ? 2'b10 : 2'b01) : 2'b00;
    assign gnt_addr = head_addr[gnt_sel];
    assign gnt_data = head_data[gnt_sel];

    // Clear from the issuing write, set from decode; set wins on the same register.
    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (gnt_valid) clr_mask[gnt_addr] = 1'b1;
        if (reserve_valid && (reserve_addr != '0)) set_mask[reserve_addr] = 1'b1;
        conflict_next = |(set_mask & busy & ~clr_mask);
        busy_next     = ((busy & ~clr_mask) | set_mask) & ~32'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            RegWrite         <= 1'b0;
            rc               <= '0;
            dc               <= '0;
            busy             <= '0;
            reserve_conflict <= 1'b0;
            last_gnt         <= 1'b1;
        end else begin
            // A grant to register 0 still consumes the slot but never writes.
            RegWrite         <= gnt_valid && (gnt_addr != '0);
            busy             <= busy_next;
            reserve_conflict <= conflict_next;
            if (gnt_valid) begin
                rc       <= gnt_addr;
                dc       <= gnt_data;
                last_gnt <= gnt_sel;
            end
        end
    end

    assign idle = ~|not_empty && !RegWrite;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed bench for regfile_write_arbiter, checked against a
// queue-based transaction model of the two FIFOs, round-robin and scoreboard.
module tb_regfile_write_arbiter;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int FD     = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic              req0_valid = 1'b0;
    logic              req0_ready;
    logic [ADDR_W-1:0] req0_addr = '0;
    logic [DATA_W-1:0] req0_data = '0;
    logic              req1_valid = 1'b0;
    logic              req1_ready;
    logic [ADDR_W-1:0] req1_addr = '0;
    logic [DATA_W-1:0] req1_data = '0;
    logic              reserve_valid = 1'b0;
    logic [ADDR_W-1:0] reserve_addr = '0;
    logic              reserve_conflict;
    logic [31:0]       busy;
    logic              RegWrite;
    logic [ADDR_W-1:0] rc;
    logic [DATA_W-1:0] dc;
    logic              idle;

    regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_addr(req1_addr), .req1_data(req1_data),
        .reserve_valid(reserve_valid), .reserve_addr(reserve_addr),
        .reserve_conflict(reserve_conflict), .busy(busy),
        .RegWrite(RegWrite), .rc(rc), .dc(dc), .idle(idle)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: queued writes per requester, last grant, outputs.
    wr_t               q0[$];
    wr_t               q1[$];
    wr_t               s0[$];
    wr_t               s1[$];
    logic [ADDR_W-1:0] issued[$];
    logic [31:0]       m_busy;
    bit                m_last;
    logic              m_we;
    logic [ADDR_W-1:0] m_rc;
    logic [DATA_W-1:0] m_dc;
    logic              m_conf;
    bit                acc0;
    bit                acc1;
    bit                saw_full1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        q0.delete();
        q1.delete();
        m_busy = '0;
        m_last = 1'b1;
        m_we   = 1'b0;
        m_rc   = '0;
        m_dc   = '0;
        m_conf = 1'b0;
    endfunction

    // One clock: predict from the pre-edge inputs, step the edge, compare outputs.
    task automatic cycle();
        int  g;
        wr_t e;
        check("ready0", req0_ready, q0.size() < FD);
        check("ready1", req1_ready, q1.size() < FD);
        if (!req1_ready) saw_full1 = 1'b1;
        acc0 = req0_valid && (q0.size() < FD);
        acc1 = req1_valid && (q1.size() < FD);
        g = -1;
        if (q0.size() > 0 && q1.size() > 0) g = m_last ? 0 : 1;
        else if (q0.size() > 0)             g = 0;
        else if (q1.size() > 0)             g = 1;
        m_conf = 1'b0;
        m_we   = 1'b0;
        if (g >= 0) begin
            if (g == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            m_we   = (e.addr != 0);
            m_rc   = e.addr;
            m_dc   = e.data;
            m_last = (g == 1);
            m_busy[e.addr] = 1'b0;
        end
        if (reserve_valid && reserve_addr != 0) begin
            if (m_busy[reserve_addr]) m_conf = 1'b1;
            m_busy[reserve_addr] = 1'b1;
        end
        if (acc0) q0.push_back(wr_t'{req0_addr, req0_data});
        if (acc1) q1.push_back(wr_t'{req1_addr, req1_data});
        @(posedge clk);
        #1;
        if (RegWrite) issued.push_back(rc);
        check("RegWrite", RegWrite, m_we);
        check("rc", rc, m_rc);
        check("dc", dc, m_dc);
        check("busy", busy, m_busy);
        check("reserve_conflict", reserve_conflict, m_conf);
        check("idle", idle, (q0.size() == 0) && (q1.size() == 0) && !m_we);
    endtask

    task automatic do_reset();
        req0_valid    = 1'b0;
        req1_valid    = 1'b0;
        reserve_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_RegWrite", RegWrite, 0);
        check("rst_rc", rc, 0);
        check("rst_dc", dc, 0);
        check("rst_busy", busy, 0);
        check("rst_conflict", reserve_conflict, 0);
        check("rst_ready0", req0_ready, 1);
        check("rst_ready1", req1_ready, 1);
        check("rst_idle", idle, 1);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Offers the pending stream entries, advancing each only on acceptance.
    task automatic run(input int ncyc, input int vprob, input int rprob);
        for (int i = 0; i < ncyc; i++) begin
            req0_valid = (s0.size() > 0) && ($urandom_range(99) < vprob);
            req1_valid = (s1.size() > 0) && ($urandom_range(99) < vprob);
            if (s0.size() > 0) begin
                req0_addr = s0[0].addr;
                req0_data = s0[0].data;
            end
            if (s1.size() > 0) begin
                req1_addr = s1[0].addr;
                req1_data = s1[0].data;
            end
            if (rprob > 0) begin
                reserve_valid = ($urandom_range(99) < rprob);
                reserve_addr  = ADDR_W'($urandom_range(31));
            end
            cycle();
            if (acc0) s0.delete(0);
            if (acc1) s1.delete(0);
        end
        req0_valid    = 1'b0;
        req1_valid    = 1'b0;
        reserve_valid = 1'b0;
    endtask

    initial begin
        logic [ADDR_W-1:0] exp_ord [6];
        wr_t               e;
        exp_ord = '{5'd1, 5'd9, 5'd2, 5'd10, 5'd3, 5'd11};

        do_reset();

        // Contention straight from reset: req0 wins the first tie, then strict alternation.
        issued.delete();
        for (int i = 0; i < 3; i++) begin
            s0.push_back(wr_t'{ADDR_W'(1 + i), $urandom()});
            s1.push_back(wr_t'{ADDR_W'(9 + i), $urandom()});
        end
        run(10, 100, 0);
        check("cont_count", issued.size(), 6);
        for (int i = 0; i < 6 && i < issued.size(); i++) check("cont_order", issued[i], exp_ord[i]);

        // Single write with first-transaction latency.
        do_reset();
        req0_valid = 1'b1;
        req0_addr  = 5'd5;
        req0_data  = 32'hDEADBEEF;
        cycle();
        req0_valid = 1'b0;
        cycle();
        check("sw_we", RegWrite, 1);
        check("sw_rc", rc, 5);
        check("sw_dc", dc, 32'hDEADBEEF);
        cycle();
        check("sw_we_off", RegWrite, 0);
        check("sw_idle", idle, 1);

        // Register 0 write consumes a slot but never asserts RegWrite.
        req0_valid = 1'b1;
        req0_addr  = 5'd0;
        req0_data  = 32'h1234;
        cycle();
        req0_valid = 1'b0;
        cycle();
        check("r0_we", RegWrite, 0);
        check("r0_idle", idle, 1);

        // Backpressure on requester 1 while both stream four entries.
        saw_full1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s0.push_back(wr_t'{ADDR_W'(16 + i), $urandom()});
            s1.push_back(wr_t'{ADDR_W'(24 + i), $urandom()});
        end
        run(14, 100, 0);
        check("bp_full_seen", saw_full1, 1);
        check("bp_drained", s0.size() + s1.size(), 0);

        // Scoreboard: set, conflict, and set winning over a same-edge clear.
        reserve_valid = 1'b1;
        reserve_addr  = 5'd7;
        cycle();
        check("sb_set7", busy[7], 1);
        cycle();
        check("sb_conflict", reserve_conflict, 1);
        reserve_valid = 1'b0;
        req1_valid    = 1'b1;
        req1_addr     = 5'd7;
        req1_data     = 32'hCAFE0007;
        cycle();
        req1_valid    = 1'b0;
        reserve_valid = 1'b1;
        cycle();
        check("sb_set_wins", busy[7], 1);
        check("sb_issue7", rc, 7);
        reserve_valid = 1'b0;
        cycle();

        // Reset in the middle of traffic with busy = 0x86.
        reserve_valid = 1'b1;
        reserve_addr  = 5'd1;
        cycle();
        reserve_addr  = 5'd2;
        cycle();
        reserve_valid = 1'b0;
        check("pre_rst_busy", busy, 32'h0000_0086);
        for (int i = 0; i < 3; i++) begin
            s0.push_back(wr_t'{ADDR_W'(20 + i), $urandom()});
            s1.push_back(wr_t'{ADDR_W'(26 + i), $urandom()});
        end
        run(3, 100, 0);
        check("pre_rst_busy_idle", idle, 0);
        do_reset();
        s0.delete();
        s1.delete();
        repeat (3) cycle();

        // Randomized traffic with random reservations.
        for (int blk = 0; blk < 40; blk++) begin
            for (int i = 0; i < 4; i++) begin
                e.addr = ADDR_W'($urandom_range(31));
                e.data = $urandom();
                s0.push_back(e);
                e.addr = ADDR_W'($urandom_range(31));
                e.data = $urandom();
                s1.push_back(e);
            end
            run(10, 70, 30);
        end
        run(40, 100, 0);
        repeat (3) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
